// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: per-stage valid/flush control, load-use and
// memory-wait stalls, redirect flushes, a debug halt/drain FSM and saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int unsigned DRAIN_CYC = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             halt_req,
  input  logic             cnt_clr,
  output logic             pc_valid,
  output logic             if_id_valid,
  output logic             id_ex_valid,
  output logic             ex_mem_valid,
  output logic             mem_wb_valid,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             halt_ack,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned DW = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            halt_ack_q;
  logic [CNT_W-1:0] stall_q, flush_q;

  logic stall_mem, load_use, drain_dec, stall_inc, flush_inc;

  assign stall_mem = mem_req & ~mem_ready;
  assign load_use  = ex_mem_read & (ex_rd != 5'd0) &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
  assign drain_dec = (state_q == StDrain) & ~stall_mem & ~load_use;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StRun;
      drain_q    <= DW'(DRAIN_CYC);
      halt_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      halt_ack_q <= (state_d == StHalted);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      StRun: begin
        if (halt_req && !stall_mem) state_d = StDrain;
      end
      StDrain: begin
        if (!halt_req) begin
          state_d = StRun;
          drain_d = DW'(DRAIN_CYC);
        end else if (drain_dec) begin
          if (drain_q == DW'(1)) begin
            state_d = StHalted;
            drain_d = DW'(DRAIN_CYC);
          end else begin
            drain_d = drain_q - DW'(1);
          end
        end
      end
      StHalted: begin
        if (!halt_req) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // Output logic; everything forced low while reset is asserted
  always_comb begin
    pc_valid     = 1'b0;
    if_id_valid  = 1'b0;
    id_ex_valid  = 1'b0;
    ex_mem_valid = 1'b0;
    mem_wb_valid = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (!reset) begin
      case (state_q)
        StRun, StDrain: begin
          if (stall_mem) begin
            mem_wb_flush = 1'b1;
          end else if (ex_redirect) begin
            pc_valid     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_valid = 1'b1;
            mem_wb_valid = 1'b1;
          end else if (load_use) begin
            id_ex_flush  = 1'b1;
            ex_mem_valid = 1'b1;
            mem_wb_valid = 1'b1;
          end else if (state_q == StRun) begin
            pc_valid     = 1'b1;
            if_id_valid  = 1'b1;
            id_ex_valid  = 1'b1;
            ex_mem_valid = 1'b1;
            mem_wb_valid = 1'b1;
          end else begin
            // Stop fetching and bubble IF/ID so only older instructions retire
            if_id_flush  = 1'b1;
            id_ex_valid  = 1'b1;
            ex_mem_valid = 1'b1;
            mem_wb_valid = 1'b1;
          end
        end
        StHalted: mem_wb_flush = 1'b1;
        default: ;
      endcase
    end
  end

  assign stall_inc = (state_q == StRun) & ~pc_valid;
  assign flush_inc = (state_q != StHalted) & ~stall_mem & ex_redirect;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (cnt_clr) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_inc && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign halt_ack  = halt_ack_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a RUN-state vector table plus hand-written
// sequences for stalls, redirects, halt/drain, counter saturation and async reset.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CW = 4;

  // Output order: {pc, if_id_v, id_ex_v, ex_mem_v, mem_wb_v, if_id_f, id_ex_f, ex_mem_f, mem_wb_f}
  localparam logic [8:0] ONorm  = 9'b111110000;
  localparam logic [8:0] OLoadU = 9'b000110100;
  localparam logic [8:0] OFrz   = 9'b000000001;
  localparam logic [8:0] ORedir = 9'b100111100;
  localparam logic [8:0] ODrain = 9'b001111000;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, mem_req, mem_ready;
  logic halt_req, cnt_clr;
  logic pc_valid, if_id_valid, id_ex_valid, ex_mem_valid, mem_wb_valid;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, halt_ack;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [8:0] ov;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       mr;
    logic [4:0] rd;
    logic       redir;
    logic       mreq;
    logic       mrdy;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  assign ov = {pc_valid, if_id_valid, id_ex_valid, ex_mem_valid, mem_wb_valid,
               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

  pipe_hazard_ctrl #(.DRAIN_CYC(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req), .cnt_clr(cnt_clr),
    .pc_valid(pc_valid), .if_id_valid(if_id_valid), .id_ex_valid(id_ex_valid),
    .ex_mem_valid(ex_mem_valid), .mem_wb_valid(mem_wb_valid),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .mem_wb_flush(mem_wb_flush), .halt_ack(halt_ack),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else passed++;
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0; ex_rd = 5'd0; ex_redirect = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_uses_rs2 = 1'b1; id_rs2 = 5'd5;
  endtask

  task automatic clear_cnts();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  initial begin
    int n;
    vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ONorm};
    vecs[1]  = '{5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, OLoadU};
    vecs[2]  = '{5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, ONorm};
    vecs[3]  = '{5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, ONorm};
    vecs[4]  = '{5'd7, 5'd3, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, OLoadU};
    vecs[5]  = '{5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, ONorm};
    vecs[6]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, OFrz};
    vecs[7]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, ONorm};
    vecs[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, ORedir};
    vecs[9]  = '{5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, ORedir};
    vecs[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, OFrz};

    reset = 1'b1; halt_req = 1'b0; cnt_clr = 1'b0;
    idle_inputs();
    #1;
    chk("reset_outs", 32'(ov), 32'd0);
    chk("reset_ack", 32'(halt_ack), 32'd0);
    chk("reset_stall", 32'(stall_cnt), 32'd0);
    chk("reset_flush", 32'(flush_cnt), 32'd0);
    #12 reset = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) begin
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
      ex_mem_read = vecs[i].mr; ex_rd = vecs[i].rd; ex_redirect = vecs[i].redir;
      mem_req = vecs[i].mreq; mem_ready = vecs[i].mrdy;
      #1;
      chk($sformatf("vec%0d", i), 32'(ov), 32'(vecs[i].exp));
      tick();
    end
    idle_inputs();
    clear_cnts();
    chk("clr_stall", 32'(stall_cnt), 32'd0);
    chk("clr_flush", 32'(flush_cnt), 32'd0);

    // Single-cycle load-use stall, then the load moves on
    set_load_use();
    #1 chk("lu_outs", 32'(ov), 32'(OLoadU));
    tick();
    idle_inputs();
    #1 chk("lu_after", 32'(ov), 32'(ONorm));
    chk("lu_stall", 32'(stall_cnt), 32'd1);

    // Three-cycle memory wait
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("mw%0d", i), 32'(ov), 32'(OFrz));
      tick();
    end
    chk("mw_stall", 32'(stall_cnt), 32'd4);
    mem_ready = 1'b1;
    #1 chk("mw_ready", 32'(ov), 32'(ONorm));
    tick();
    chk("mw_ready_stall", 32'(stall_cnt), 32'd4);
    idle_inputs();

    // Redirect beats load-use
    set_load_use(); ex_redirect = 1'b1;
    #1 chk("rl_outs", 32'(ov), 32'(ORedir));
    tick();
    chk("rl_flush", 32'(flush_cnt), 32'd1);
    chk("rl_stall", 32'(stall_cnt), 32'd4);
    idle_inputs();

    // Redirect held through a memory wait
    ex_redirect = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    #1 chk("rm_frz", 32'(ov), 32'(OFrz));
    tick();
    chk("rm_flush0", 32'(flush_cnt), 32'd1);
    mem_ready = 1'b1;
    #1 chk("rm_redir", 32'(ov), 32'(ORedir));
    tick();
    chk("rm_flush1", 32'(flush_cnt), 32'd2);
    chk("rm_stall", 32'(stall_cnt), 32'd5);
    idle_inputs();

    // Halt with no hazards
    halt_req = 1'b1;
    tick();
    #1 chk("drain_outs", 32'(ov), 32'(ODrain));
    n = 0;
    while (!halt_ack && n < 20) begin
      tick();
      n++;
    end
    chk("drain_len", 32'(n), 32'd4);
    chk("halted_outs", 32'(ov), 32'(OFrz));
    chk("halted_ack", 32'(halt_ack), 32'd1);
    halt_req = 1'b0;
    tick();
    chk("resume_ack", 32'(halt_ack), 32'd0);
    chk("resume_outs", 32'(ov), 32'(ONorm));

    // Halt with a two-cycle memory wait mid-drain
    halt_req = 1'b1;
    tick();
    n = 0;
    while (!halt_ack && n < 20) begin
      mem_req = (n == 2 || n == 3); mem_ready = 1'b0;
      tick();
      n++;
    end
    idle_inputs();
    chk("drain_mw_len", 32'(n), 32'd6);
    chk("drain_mw_stall", 32'(stall_cnt), 32'd5);
    halt_req = 1'b0;
    tick();
    chk("resume2_ack", 32'(halt_ack), 32'd0);

    // Stall counter saturation
    clear_cnts();
    set_load_use();
    repeat (20) tick();
    chk("sat_stall", 32'(stall_cnt), 32'd15);
    idle_inputs();
    clear_cnts();
    chk("sat_clr", 32'(stall_cnt), 32'd0);

    // Asynchronous reset in the middle of a drain
    set_load_use();
    tick();
    tick();
    idle_inputs();
    ex_redirect = 1'b1;
    tick();
    ex_redirect = 1'b0;
    chk("pre_rst_stall", 32'(stall_cnt), 32'd2);
    halt_req = 1'b1;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    chk("rst_outs", 32'(ov), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_flush", 32'(flush_cnt), 32'd0);
    halt_req = 1'b0;
    tick();
    reset = 1'b0;
    #1 chk("rst_run_outs", 32'(ov), 32'(ONorm));
    chk("rst_run_ack", 32'(halt_ack), 32'd0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage mini CPU. It drives the valid (enable) and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, handling memory-wait freezes, EX-stage redirects and load-use stalls. It also runs a halt/drain FSM for debug stop and keeps saturating stall and flush performance counters.

Parameters:
DRAIN_CYC, 4, number of advancing cycles needed to retire everything from ID/EX onward before HALTED
CNT_W, 16, width of stall_cnt and flush_cnt

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
id_rs1  input  5  rs1 index of the instruction in ID
id_rs2  input  5  rs2 index of the instruction in ID
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
ex_mem_read  input  1  instruction in EX is a load
ex_rd  input  5  destination index of the instruction in EX
ex_redirect  input  1  EX resolved a taken branch or jump; level, held while the instruction sits in EX
mem_req  input  1  MEM stage is accessing data memory this cycle
mem_ready  input  1  data memory completes the access this cycle
halt_req  input  1  debug halt request, level
cnt_clr  input  1  synchronous clear of both counters
pc_valid  output  1  PC register load enable
if_id_valid, id_ex_valid, ex_mem_valid, mem_wb_valid  output  1 each  pipeline register enables
if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  output  1 each  pipeline register flushes; a flush overrides valid in the register
halt_ack  output  1  pipeline is halted
stall_cnt  output  CNT_W  cycles stalled in RUN
flush_cnt  output  CNT_W  redirect flush cycles

Behaviour:
- Reset is asynchronous and active-high. Reset values: state=RUN, drain_cnt=DRAIN_CYC, counters=0, halt_ack=0. While reset is high, every valid and flush output is 0.
- Derived terms: stall_mem = mem_req & ~mem_ready. load_use = ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Valid and flush outputs are combinational from state and inputs, with zero latency. Whenever a flush is 1, the matching valid is driven 0. Unlisted outputs are 0.
- RUN state, applied in strict priority order:
  1. stall_mem: mem_wb_flush=1; all other valid and flush outputs 0 (full freeze, WB bubble).
  2. ex_redirect: pc_valid=1, if_id_flush=1, id_ex_flush=1, ex_mem_valid=1, mem_wb_valid=1.
  3. load_use: id_ex_flush=1, ex_mem_valid=1, mem_wb_valid=1 (PC and IF/ID hold).
  4. Otherwise all four valids and pc_valid are 1.
- FSM transitions:
  - RUN->DRAIN on halt_req & ~stall_mem. The transition cycle still uses the RUN outputs above, so a coincident redirect is honoured.
  - DRAIN: outputs are the same as RUN items 1-3. In the default case: pc_valid=0, if_id_flush=1, id_ex_valid=ex_mem_valid=mem_wb_valid=1.
  - drain_cnt decrements only on DRAIN cycles with no stall_mem and no load_use.
  - DRAIN->HALTED when drain_cnt==1 and it decrements; drain_cnt then reloads to DRAIN_CYC.
  - DRAIN->RUN if halt_req=0. drain_cnt reloads to DRAIN_CYC; injected bubbles are harmless.
  - HALTED: mem_wb_flush=1, all else frozen, halt_ack=1 (registered, asserted exactly in HALTED).
  - HALTED->RUN when halt_req=0. halt_ack drops the same edge.
- Counters:
  - stall_cnt +1 on each RUN cycle with pc_valid=0 (stall_mem or load_use).
  - flush_cnt +1 on each cycle with if_id_flush due to ex_redirect, in RUN or DRAIN.
  - Both saturate at 2^CNT_W-1.
  - cnt_clr zeroes both counters and has priority over increment.
- Reset asserted mid-drain or in HALTED returns the block to RUN immediately and asynchronously.

Test Plan:
- Load x5 in EX (ex_mem_read=1, ex_rd=5), ID add reads rs2=5 -> exactly 1 cycle with pc_valid=0, if_id_valid=0, id_ex_flush=1; stall_cnt 0->1. Repeat with ex_rd=0 -> no stall.
- mem_req=1, mem_ready=0 for 3 cycles -> 3 cycles with only mem_wb_flush=1; stall_cnt=3; normal flow resumes on the mem_ready cycle.
- ex_redirect=1 and load_use=1 in the same cycle -> redirect wins: pc_valid=1, if_id_flush=id_ex_flush=1; flush_cnt=1, stall_cnt unchanged.
- ex_redirect=1 during stall_mem -> freeze only; redirect outputs appear on the first cycle with mem_ready=1.
- halt_req=1 held, DRAIN_CYC=4, no hazards -> 4 DRAIN cycles then HALTED with halt_ack=1. Insert a 2-cycle mem wait mid-drain -> 6 cycles. Drop halt_req -> RUN next cycle, halt_ack=0.
- CNT_W=4, force 20 load-use stalls -> stall_cnt saturates at 15. Pulse cnt_clr -> 0. Assert reset in DRAIN -> RUN, all valid and flush outputs 0 during reset, counters 0.
